dma_stream_engine: RTL
======================

// Module: dma_stream_engine
// PURPOSE
// Parametrised DDR burst DMA between the accelerator's input/output stream FIFOs and one MIG user port.
// Streams host data from the input FIFO into DRAM and reads DRAM back into the output FIFO.
// Each direction has a programmable base address and burst count. Writes and reads are arbitrated round-robin.
// Data paths are pipelined at one word per clock, with full cmd_full/wr_full/rd_empty back-pressure.
// PARAMETERS
// DATA_W      32    user data width; MIG port width; multiple of 8
// ADDR_W      30    byte-address width
// BURST_LEN   32    words per MIG command, 2..64, even; cmd_bl = BURST_LEN-1
// FIFO_DEPTH  1024  depth of ib/ob stream FIFOs
// CNT_W       10    width of ib_count/ob_count
// LEN_W       16    width of burst-count registers
// PORTS
// clk           in   1        system clock, all logic rising-edge
// reset_n       in   1        asynchronous active-low reset
// calib_done    in   1        MIG calibration complete; no command issued while 0
// wr_start      in   1        1-cycle pulse: latch wr_base/wr_bursts, arm DRAM write job
// wr_base       in   ADDR_W   write job start byte address, burst aligned
// wr_bursts     in   LEN_W    write job length in bursts
// rd_start      in   1        1-cycle pulse: latch rd_base/rd_bursts, arm DRAM read job
// rd_base       in   ADDR_W   read job start byte address, burst aligned
// rd_bursts     in   LEN_W    read job length in bursts
// wr_done       out  1        sticky: write job finished; cleared by wr_start
// rd_done       out  1        sticky: read job finished; cleared by rd_start
// busy          out  1        FSM not in IDLE
// ib_re         out  1        input FIFO read enable
// ib_data       in   DATA_W   input FIFO data, valid with ib_valid
// ib_valid      in   1        ib_data valid, 1 cycle after ib_re
// ib_count      in   CNT_W    input FIFO occupancy
// ob_we         out  1        output FIFO write enable
// ob_data       out  DATA_W   output FIFO write data
// ob_count      in   CNT_W    output FIFO occupancy
// cmd_en/cmd_instr[2:0]/cmd_byte_addr[ADDR_W]/cmd_bl[5:0]  out  MIG command; cmd_full in
// wr_en/wr_data[DATA_W]/wr_mask[DATA_W/8]  out  MIG write data, mask=0; wr_full in
// rd_en out 1 / rd_data in DATA_W / rd_empty in 1  MIG read data, first-word-fall-through
// BEHAVIOUR
// - Reset: state=IDLE. All strobes 0. cmd_instr, cmd_byte_addr, ob_data, wr_data, job counters = 0. done flags = 0. Skid buffer empty.
// - Jobs: a start pulse accepted only when that direction is idle (remaining==0 and not active); otherwise ignored.
//   bursts==0 sets done the next cycle. Done flag set the cycle the last burst's command (write) or last word (read) completes.
// - IDLE eligibility: wr_elig = calib_done & wr_remaining>0 & ib_count>=BURST_LEN.
//   rd_elig = calib_done & rd_remaining>0 & ob_count<=FIFO_DEPTH-1-BURST_LEN.
//   If both are eligible, serve the direction not served last; after reset, write wins.
// - WR_DATA: ib_re=1 while fetched<BURST_LEN & !wr_full & skid empty.
//   Each ib_valid word -> wr_en/wr_data in the same cycle if !wr_full, else into a 1-entry skid register. Skid drains first once wr_full=0.
//   Go to WR_CMD after BURST_LEN words have been written.
// - WR_CMD: wait for !cmd_full, then 1-cycle cmd_en, instr 3'b000, addr=wr_addr.
//   Then wr_addr += BURST_LEN*DATA_W/8, wr_remaining--, go to IDLE.
// - RD_CMD: wait for !cmd_full, then cmd_en, instr 3'b001, addr=rd_addr. Advance rd_addr, go to RD_DATA.
// - RD_DATA: rd_en = !rd_empty & drained<BURST_LEN. ob_we/ob_data registered 1 cycle after rd_en.
//   After the BURST_LEN-th word: rd_remaining--, return to IDLE.
// - Address wraps modulo 2^ADDR_W without error.
// - calib_done falling mid-burst: the current burst completes; no new burst starts.
// - Async reset mid-burst: immediate return to IDLE, jobs cleared, partial burst discarded; the MIG must be reset alongside.
// - ib_count/ob_count are checked only in IDLE; ob space is reserved for a whole burst before the command is issued.
// TESTING
// - BURST_LEN=32: wr_start base 0x100, bursts 2, 64 words in ib -> cmd addr 0x100 then 0x180 instr 0; wr_en data in order; wr_done=1.
// - Hold wr_full=1 for 5 cycles mid-burst -> no word lost or duplicated (skid used); cmd issued only after 32 wr_en.
// - rd job base 0x200, bursts 1, rd_empty toggling -> 32 ob_we in order, 1-cycle latency after rd_en; rd_done=1.
// - Both jobs armed, 3 bursts each, FIFOs ready -> command order W,R,W,R,W,R.
// - ob_count=FIFO_DEPTH-BURST_LEN -> no read cmd until ob_count drops to 991; cmd_full=1 -> cmd_en held off.
// - reset_n low during WR_DATA word 10 -> all outputs 0 asynchronously; wr_start after release restarts cleanly.

Source files
------------

// File: rtl/dma_stream_engine.sv
// Burst DMA between the ib/ob stream FIFOs and one MIG user port; one word per clock, write data is combinational to the MIG.
// Back-pressure: wr_full parks one in-flight word in a skid register, cmd_full holds the command, rd_empty stalls rd_en.
module dma_stream_engine #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 30,
    parameter int BURST_LEN  = 32,
    parameter int FIFO_DEPTH = 1024,
    parameter int CNT_W      = 10,
    parameter int LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  calib_done,
    input  logic                  wr_start,
    input  logic [ADDR_W-1:0]     wr_base,
    input  logic [LEN_W-1:0]      wr_bursts,
    input  logic                  rd_start,
    input  logic [ADDR_W-1:0]     rd_base,
    input  logic [LEN_W-1:0]      rd_bursts,
    output logic                  wr_done,
    output logic                  rd_done,
    output logic                  busy,
    output logic                  ib_re,
    input  logic [DATA_W-1:0]     ib_data,
    input  logic                  ib_valid,
    input  logic [CNT_W-1:0]      ib_count,
    output logic                  ob_we,
    output logic [DATA_W-1:0]     ob_data,
    input  logic [CNT_W-1:0]      ob_count,
    output logic                  cmd_en,
    output logic [2:0]            cmd_instr,
    output logic [ADDR_W-1:0]     cmd_byte_addr,
    output logic [5:0]            cmd_bl,
    input  logic                  cmd_full,
    output logic                  wr_en,
    output logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W/8-1:0]   wr_mask,
    input  logic                  wr_full,
    output logic                  rd_en,
    input  logic [DATA_W-1:0]     rd_data,
    input  logic                  rd_empty
);

    localparam int BC_W = $clog2(BURST_LEN + 1);
    localparam logic [BC_W-1:0]   BL_C        = BC_W'(BURST_LEN);
    localparam logic [BC_W-1:0]   BL_LAST     = BC_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
    localparam logic [CNT_W-1:0]  IB_NEED     = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  OB_LIMIT    = CNT_W'(FIFO_DEPTH - 1 - BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_WR_CMD,
        S_RD_CMD,
        S_RD_DATA
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]    wr_rem_q, wr_rem_d;
    logic [LEN_W-1:0]    rd_rem_q, rd_rem_d;
    logic                wr_done_q, wr_done_d;
    logic                rd_done_q, rd_done_d;
    logic                last_wr_q, last_wr_d;
    logic [BC_W-1:0]     fet_q, fet_d;
    logic [BC_W-1:0]     cnt_q, cnt_d;
    logic                skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0]   skid_dat_q, skid_dat_d;
    logic                ob_we_q, ob_we_d;
    logic [DATA_W-1:0]   ob_dat_q, ob_dat_d;

    logic wr_active, rd_active, wr_elig, rd_elig;

    assign wr_active = (state_q == S_WR_DATA) || (state_q == S_WR_CMD);
    assign rd_active = (state_q == S_RD_CMD) || (state_q == S_RD_DATA);
    // ob space is reserved for a full burst before the read command goes out
    assign wr_elig = calib_done && (wr_rem_q != '0) && (ib_count >= IB_NEED);
    assign rd_elig = calib_done && (rd_rem_q != '0) && (ob_count <= OB_LIMIT);

    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        wr_rem_d      = wr_rem_q;
        rd_rem_d      = rd_rem_q;
        wr_done_d     = wr_done_q;
        rd_done_d     = rd_done_q;
        last_wr_d     = last_wr_q;
        fet_d         = fet_q;
        cnt_d         = cnt_q;
        skid_vld_d    = skid_vld_q;
        skid_dat_d    = skid_dat_q;
        ob_we_d       = 1'b0;
        ob_dat_d      = ob_dat_q;
        ib_re         = 1'b0;
        wr_en         = 1'b0;
        wr_data       = '0;
        cmd_en        = 1'b0;
        cmd_instr     = 3'b000;
        cmd_byte_addr = '0;
        rd_en         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wr_elig && (!rd_elig || !last_wr_q)) begin
                    state_d   = S_WR_DATA;
                    last_wr_d = 1'b1;
                    fet_d     = '0;
                    cnt_d     = '0;
                end else if (rd_elig) begin
                    state_d   = S_RD_CMD;
                    last_wr_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            S_WR_DATA: begin
                // at most one fetched word is ever in flight, so one skid entry suffices
                ib_re = (fet_q < BL_C) && !wr_full && !skid_vld_q;
                if (ib_re) begin
                    fet_d = fet_q + BC_W'(1);
                end
                if (skid_vld_q) begin
                    if (!wr_full) begin
                        wr_en      = 1'b1;
                        wr_data    = skid_dat_q;
                        skid_vld_d = 1'b0;
                    end
                end else if (ib_valid) begin
                    if (!wr_full) begin
                        wr_en   = 1'b1;
                        wr_data = ib_data;
                    end else begin
                        skid_vld_d = 1'b1;
                        skid_dat_d = ib_data;
                    end
                end
                if (wr_en) begin
                    cnt_d = cnt_q + BC_W'(1);
                    if (cnt_q == BL_LAST) begin
                        state_d = S_WR_CMD;
                    end
                end
            end
            S_WR_CMD: begin
                cmd_instr     = 3'b000;
                cmd_byte_addr = wr_addr_q;
                if (!cmd_full) begin
                    cmd_en    = 1'b1;
                    wr_addr_d = wr_addr_q + BURST_BYTES;
                    wr_rem_d  = wr_rem_q - LEN_W'(1);
                    if (wr_rem_q == LEN_W'(1)) begin
                        wr_done_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            S_RD_CMD: begin
                cmd_instr     = 3'b001;
                cmd_byte_addr = rd_addr_q;
                if (!cmd_full) begin
                    cmd_en    = 1'b1;
                    rd_addr_d = rd_addr_q + BURST_BYTES;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                rd_en = !rd_empty && (cnt_q < BL_C);
                if (rd_en) begin
                    ob_we_d  = 1'b1;
                    ob_dat_d = rd_data;
                    cnt_d    = cnt_q + BC_W'(1);
                    if (cnt_q == BL_LAST) begin
                        rd_rem_d = rd_rem_q - LEN_W'(1);
                        if (rd_rem_q == LEN_W'(1)) begin
                            rd_done_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // a start is only honoured while its direction has nothing outstanding
        if (wr_start && (wr_rem_q == '0) && !wr_active) begin
            wr_addr_d = wr_base;
            wr_rem_d  = wr_bursts;
            wr_done_d = (wr_bursts == '0);
        end
        if (rd_start && (rd_rem_q == '0) && !rd_active) begin
            rd_addr_d = rd_base;
            rd_rem_d  = rd_bursts;
            rd_done_d = (rd_bursts == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            wr_rem_q   <= '0;
            rd_rem_q   <= '0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            last_wr_q  <= 1'b0;
            fet_q      <= '0;
            cnt_q      <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            ob_we_q    <= 1'b0;
            ob_dat_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            wr_rem_q   <= wr_rem_d;
            rd_rem_q   <= rd_rem_d;
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
            last_wr_q  <= last_wr_d;
            fet_q      <= fet_d;
            cnt_q      <= cnt_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            ob_we_q    <= ob_we_d;
            ob_dat_q   <= ob_dat_d;
        end
    end

    assign wr_done = wr_done_q;
    assign rd_done = rd_done_q;
    assign busy    = (state_q != S_IDLE);
    assign ob_we   = ob_we_q;
    assign ob_data = ob_dat_q;
    assign cmd_bl  = 6'(BURST_LEN - 1);
    assign wr_mask = '0;

endmodule
